sram_1rw1r_ctrl: RTL and testbench



---
 rtl/sram_1rw1r_ctrl_pkg.sv | 9 +
 rtl/sram_1rw1r_ctrl_rr_arbiter2.sv | 15 +
 rtl/sram_1rw1r_ctrl.sv | 132 +++++++++++++
 tb/tb_sram_1rw1r_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_1rw1r_ctrl_pkg.sv
// sram_ctrl_defs: shared widths, controller states and requester IDs for sram_1rw1r_ctrl
package sram_ctrl_defs;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 9;
    localparam int NUM_WMASKS = 4;
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
    localparam logic REQ_ID_0 = 1'b0;
    localparam logic REQ_ID_1 = 1'b1;
endpackage

// File: rtl/sram_1rw1r_ctrl_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin arbiter, combinational grant, registered last-grant pointer
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    logic r_last;
    assign o_gnt[0] = i_req[0] & (~i_req[1] | r_last);
    assign o_gnt[1] = i_req[1] & (~i_req[0] | ~r_last);
    // remember the latest winner so the other requester takes the next tie
    always_ff @(posedge clk)
        if (rst) r_last <= 1'b1;
        else if (|o_gnt) r_last <= o_gnt[1];
endmodule

// File: rtl/sram_1rw1r_ctrl.sv
// sram_1rw1r_ctrl: fronts a 1RW/1R SRAM macro, arbitrates two requesters on port 0; SRAM_INIT_EN adds a zero-fill sweep
module sram_1rw1r_ctrl
    import sram_ctrl_defs::*;
#(
    parameter int DATA_WIDTH = sram_ctrl_defs::DATA_WIDTH,
    parameter int ADDR_WIDTH = sram_ctrl_defs::ADDR_WIDTH,
    parameter int NUM_WMASKS = sram_ctrl_defs::NUM_WMASKS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [NUM_WMASKS-1:0] req0_wmask,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [NUM_WMASKS-1:0] req1_wmask,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_rdata,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_resp_valid,
    output logic [DATA_WIDTH-1:0] rd_resp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1,
    output logic                  init_done
);
    logic                  w_run;
    logic                  w_init;
    logic [ADDR_WIDTH-1:0] w_init_addr;
    logic [1:0]            w_gnt;
    logic                  w_gnt_any;
    logic                  w_gnt_id;
    logic                  w_we;
    logic [NUM_WMASKS-1:0] w_wmask;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_conflict;
    logic                  r_tag_valid;
    logic                  r_tag_id;
    logic                  r_rd_valid;

`ifdef SRAM_INIT_EN
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_init_done;
    // zero-fill every word once, then hand the macro over to the requesters
    always_ff @(posedge clk)
        if (rst) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) begin
                r_state     <= ST_RUN;
                r_init_done <= 1'b1;
            end
        end
    assign w_run       = !rst && r_state == ST_RUN;
    assign w_init      = !rst && r_state == ST_INIT;
    assign w_init_addr = r_cnt;
    assign init_done   = r_init_done;
`else
    assign w_run       = !rst;
    assign w_init      = 1'b0;
    assign w_init_addr = '0;
    assign init_done   = 1'b1;
`endif

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req ({req1_valid & w_run, req0_valid & w_run}),
        .o_gnt (w_gnt)
    );

    assign w_gnt_any  = |w_gnt;
    assign w_gnt_id   = w_gnt[1] ? REQ_ID_1 : REQ_ID_0;
    assign w_we       = w_gnt_id ? req1_we    : req0_we;
    assign w_wmask    = w_gnt_id ? req1_wmask : req0_wmask;
    assign w_addr     = w_gnt_id ? req1_addr  : req0_addr;
    assign w_wdata    = w_gnt_id ? req1_wdata : req0_wdata;
    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];

    assign sram_csb0   = !(w_init || w_gnt_any);
    assign sram_web0   = !(w_init || (w_gnt_any && w_we));
    assign sram_wmask0 = w_init ? '1 : (w_gnt_any && w_we) ? w_wmask : '0;
    assign sram_addr0  = w_init ? w_init_addr : w_gnt_any ? w_addr : '0;
    assign sram_din0   = (w_gnt_any && w_we) ? w_wdata : '0;

    // a same-address write would make the port-1 read undefined, so that read waits a cycle
    assign w_conflict = w_gnt_any && w_we && (w_addr == rd_addr);
    assign rd_ready   = w_run && rd_valid && !w_conflict;
    assign sram_csb1  = !rd_ready;
    assign sram_addr1 = w_run ? rd_addr : '0;

    // tag each accepted read so next cycle's macro data is steered to its owner
    always_ff @(posedge clk)
        if (rst) begin
            r_tag_valid <= 1'b0;
            r_tag_id    <= REQ_ID_0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_tag_valid <= w_gnt_any && !w_we;
            r_tag_id    <= w_gnt_id;
            r_rd_valid  <= rd_ready;
        end

    assign resp0_valid   = !rst && r_tag_valid && r_tag_id == REQ_ID_0;
    assign resp1_valid   = !rst && r_tag_valid && r_tag_id == REQ_ID_1;
    assign resp0_rdata   = sram_dout0;
    assign resp1_rdata   = sram_dout0;
    assign rd_resp_valid = !rst && r_rd_valid;
    assign rd_resp_rdata = sram_dout1;
endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// tb_sram_1rw1r_ctrl: scoreboard bench with a behavioural 1RW/1R macro; honours SRAM_INIT_EN
module tb_sram_1rw1r_ctrl;
`ifdef SRAM_INIT_EN
    localparam logic [31:0] INIT_VAL = 32'h0000_0000;
    localparam logic        DONE_RST = 1'b0;
`else
    localparam logic [31:0] INIT_VAL = 32'hA5A5_A5A5;
    localparam logic        DONE_RST = 1'b1;
`endif
    logic        clk = 0, rst = 1;
    logic        req0_valid = 0, req0_ready, req0_we = 0;
    logic [3:0]  req0_wmask = 0;
    logic [8:0]  req0_addr = 0;
    logic [31:0] req0_wdata = 0;
    logic        resp0_valid;
    logic [31:0] resp0_rdata;
    logic        req1_valid = 0, req1_ready, req1_we = 0;
    logic [3:0]  req1_wmask = 0;
    logic [8:0]  req1_addr = 0;
    logic [31:0] req1_wdata = 0;
    logic        resp1_valid;
    logic [31:0] resp1_rdata;
    logic        rd_valid = 0, rd_ready, rd_resp_valid;
    logic [8:0]  rd_addr = 0;
    logic [31:0] rd_resp_rdata;
    logic        sram_csb0, sram_web0, sram_csb1, init_done;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0, sram_addr1;
    logic [31:0] sram_din0, sram_dout0, sram_dout1;

    int n_chk = 0, n_pass = 0;
    logic [31:0] mem [512];
    logic [31:0] shadow [512];
    logic [31:0] q0 [$], q1 [$], qr [$];
    logic pend0 = 0, pend1 = 0, pendr = 0, m_last = 1, e0, e1, ecf;

    always #5 clk = ~clk;

    sram_1rw1r_ctrl dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_wmask(req0_wmask),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_wmask(req1_wmask),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_rdata(rd_resp_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_dout0(sram_dout0), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
        .sram_dout1(sram_dout1), .init_done(init_done)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
        for (int b = 0; b < 4; b++) if (m[b]) old[8*b +: 8] = d[8*b +: 8];
        return old;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    initial begin
        foreach (mem[a]) mem[a] = 32'hA5A5_A5A5;
        foreach (shadow[a]) shadow[a] = INIT_VAL;
    end

    // behavioural macro: one-cycle registered read on both ports, byte-masked write on port 0
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] <= merge(mem[sram_addr0], sram_din0, sram_wmask0);
            else sram_dout0 <= mem[sram_addr0];
        end
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    // scoreboard: pop responses, check arbitration and port-1 gating, push expectations for accepted reads
    always @(negedge clk) begin
        if (rst) begin
            q0.delete(); q1.delete(); qr.delete();
            pend0 = 0; pend1 = 0; pendr = 0; m_last = 1;
`ifdef SRAM_INIT_EN
            foreach (shadow[a]) shadow[a] = 32'h0;
`endif
        end else begin
            chk("resp0_valid", resp0_valid, pend0);
            chk("resp1_valid", resp1_valid, pend1);
            chk("rd_resp_valid", rd_resp_valid, pendr);
            if (resp0_valid) begin
                if (q0.size() == 0) chk("resp0_unexpected", 1, 0);
                else chk("resp0_data", resp0_rdata, q0.pop_front());
            end
            if (resp1_valid) begin
                if (q1.size() == 0) chk("resp1_unexpected", 1, 0);
                else chk("resp1_data", resp1_rdata, q1.pop_front());
            end
            if (rd_resp_valid) begin
                if (qr.size() == 0) chk("rd_resp_unexpected", 1, 0);
                else chk("rd_resp_data", rd_resp_rdata, qr.pop_front());
            end
            pend0 = 0; pend1 = 0; pendr = 0;
            if (init_done) begin
                e0 = req0_valid && (!req1_valid || m_last);
                e1 = req1_valid && !e0;
                ecf = (e0 && req0_we && req0_addr == rd_addr) || (e1 && req1_we && req1_addr == rd_addr);
                chk("grant", {req1_ready, req0_ready}, {e1, e0});
                chk("csb0", sram_csb0, !(e0 || e1));
                chk("rd_ready", rd_ready, rd_valid && !ecf);
                chk("csb1", sram_csb1, !(rd_valid && !ecf));
                if (e0 || e1) m_last = e1;
                if (rd_valid && rd_ready) begin qr.push_back(shadow[rd_addr]); pendr = 1; end
                if (req0_valid && req0_ready) begin
                    if (req0_we) shadow[req0_addr] = merge(shadow[req0_addr], req0_wdata, req0_wmask);
                    else begin q0.push_back(shadow[req0_addr]); pend0 = 1; end
                end
                if (req1_valid && req1_ready) begin
                    if (req1_we) shadow[req1_addr] = merge(shadow[req1_addr], req1_wdata, req1_wmask);
                    else begin q1.push_back(shadow[req1_addr]); pend1 = 1; end
                end
            end
        end
    end

    task automatic acc(input logic id, input logic we, input logic [3:0] m, input logic [8:0] a, input logic [31:0] d);
        bit ok;
        ok = 0;
        if (!id) begin req0_valid = 1; req0_we = we; req0_wmask = m; req0_addr = a; req0_wdata = d; end
        else begin req1_valid = 1; req1_we = we; req1_wmask = m; req1_addr = a; req1_wdata = d; end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = id ? req1_ready : req0_ready;
        end
        if (!ok) chk("acc_timeout", 0, 1);
        @(posedge clk); #1;
        if (!id) req0_valid = 0; else req1_valid = 0;
    endtask

    initial begin
        req0_valid = 1; req0_addr = 9'h1FF;
        req1_valid = 1; req1_addr = 9'h1FF;
        rd_valid = 1; rd_addr = 9'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {req0_ready, req1_ready, rd_ready}, 0);
        chk("rst_resp", {resp0_valid, resp1_valid, rd_resp_valid}, 0);
        chk("rst_csb_web", {sram_csb0, sram_csb1, sram_web0}, 3'b111);
        chk("rst_wmask0", sram_wmask0, 0);
        chk("rst_addr0", sram_addr0, 0);
        chk("rst_din0", sram_din0, 0);
        chk("rst_addr1", sram_addr1, 0);
        chk("rst_init_done", init_done, DONE_RST);
        @(posedge clk); #1 rst = 0;
`ifdef SRAM_INIT_EN
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            chk("init_done_low", init_done, 0);
            chk("init_ready", {req0_ready, req1_ready, rd_ready}, 0);
            chk("init_addr0", sram_addr0, i);
            chk("init_pins", {sram_csb0, sram_web0, sram_wmask0, sram_din0}, {2'b00, 4'hF, 32'h0});
        end
`endif
        @(negedge clk);
        chk("run_init_done", init_done, 1);
        chk("run_first_grant", {req1_ready, req0_ready, rd_ready}, 3'b011);
        @(posedge clk); #1 req0_valid = 0; rd_valid = 0;
        @(negedge clk);
        chk("p0_1ff_data", {resp0_valid, resp0_rdata}, {1'b1, INIT_VAL});
        chk("p1_000_data", {rd_resp_valid, rd_resp_rdata}, {1'b1, INIT_VAL});
        chk("second_grant", req1_ready, 1);
        @(posedge clk); #1 req1_valid = 0;
        @(negedge clk);
        chk("req1_1ff_data", {resp1_valid, resp1_rdata}, {1'b1, INIT_VAL});
        @(posedge clk); #1;
        req0_valid = 1; req0_we = 0; req0_addr = 9'h100;
        req1_valid = 1; req1_we = 0; req1_addr = 9'h101;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k > 0) chk("alt_resp", {resp1_valid, resp0_valid}, ((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
            if (k < 6) chk("alt_grant", {req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k == 5) begin @(posedge clk); #1 req0_valid = 0; req1_valid = 0; end
        end
        @(posedge clk); #1;
        acc(0, 1, 4'b1111, 9'h010, 32'hDEADBEEF);
        acc(0, 1, 4'b0001, 9'h010, 32'h000000AA);
        acc(0, 0, 4'b0000, 9'h010, 32'h0);
        @(negedge clk);
        chk("mask_merge", {resp0_valid, resp0_rdata}, {1'b1, 32'hDEADBEAA});
        @(posedge clk); #1;
        req0_valid = 1; req0_we = 1; req0_wmask = 4'hF; req0_addr = 9'h055; req0_wdata = 32'h12345678;
        rd_valid = 1; rd_addr = 9'h055;
        @(negedge clk);
        chk("conflict_hold", {req0_ready, rd_ready, sram_csb1}, 3'b101);
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk);
        chk("conflict_retry", rd_ready, 1);
        @(posedge clk); #1 rd_valid = 0;
        @(negedge clk);
        chk("conflict_data", {rd_resp_valid, rd_resp_rdata}, {1'b1, 32'h12345678});
        @(posedge clk); #1;
        for (int c = 0; c < 60; c++) begin
            req0_valid = 1'($urandom); req0_we = 1'($urandom); req0_wmask = 4'($urandom);
            req0_addr = 9'($urandom_range(9'h40, 9'h43)); req0_wdata = $urandom;
            req1_valid = 1'($urandom); req1_we = 1'($urandom); req1_wmask = 4'($urandom);
            req1_addr = 9'($urandom_range(9'h40, 9'h43)); req1_wdata = $urandom;
            rd_valid = 1'($urandom); rd_addr = 9'($urandom_range(9'h40, 9'h43));
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0; rd_valid = 0;
        repeat (2) @(posedge clk); #1;
        acc(1, 0, 4'b0000, 9'h055, 32'h0);
        rst = 1;
        @(negedge clk);
        chk("rst_mid_resp", {resp0_valid, resp1_valid, rd_resp_valid}, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_mid_resp_after", {resp0_valid, resp1_valid}, 0);
`ifdef SRAM_INIT_EN
        chk("reinit_done_low", init_done, 0);
        chk("reinit_addr0", sram_addr0, 0);
        chk("reinit_pins", {sram_csb0, sram_web0}, 2'b00);
        @(negedge clk);
        chk("reinit_addr1", sram_addr0, 1);
        for (int i = 0; i < 600 && !init_done; i++) @(negedge clk);
        chk("reinit_complete", init_done, 1);
`else
        chk("rst_mid_init_done", init_done, 1);
`endif
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", q0.size() + q1.size() + qr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
